// File: rtl/spi_arb_pkg.sv
// -----------------------------------------------------------------------------
// spi_arb_pkg
// Shared definitions for the SPI configuration arbiter:
//   - WORD_W        : width of one configuration word sent to the SPI shifter
//   - ST_*          : 3-bit encodings of the arbiter FSM states
//   - arb_state_t   : enumerated state type built from those encodings
// -----------------------------------------------------------------------------
package spi_arb_pkg;

    localparam int WORD_W = 32;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_ISSUE      = 3'd1;
    localparam logic [2:0] ST_WAIT_START = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE  = 3'd3;
    localparam logic [2:0] ST_GAP        = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE       = ST_IDLE,
        S_ISSUE      = ST_ISSUE,
        S_WAIT_START = ST_WAIT_START,
        S_WAIT_DONE  = ST_WAIT_DONE,
        S_GAP        = ST_GAP
    } arb_state_t;

endpackage

// File: rtl/spi_rr_arbiter.sv
// -----------------------------------------------------------------------------
// spi_rr_arbiter
// Combinational winner select among up to four requesters.
// Default build: round-robin, the search starts at last_grant+1 (mod NUM_REQ).
// With SPI_ARB_FIXED_PRIO_EN defined: fixed priority, lowest valid index wins
// and last_grant is ignored.
//
// Ports:
//   valid      in  [NUM_REQ-1:0] per-requester request
//   last_grant in  [1:0]         index of the previous winner
//   winner     out [NUM_REQ-1:0] one-hot winner, 0 when nothing is valid
//   winner_id  out [1:0]         binary index of the winner
//   any_valid  out               at least one requester is valid
// -----------------------------------------------------------------------------
module spi_rr_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [1:0]         last_grant,
    output logic [NUM_REQ-1:0] winner,
    output logic [1:0]         winner_id,
    output logic               any_valid
);

    // Zero-extend to four lanes so a 2-bit index is always in range.
    logic [3:0] valid_pad;
    logic       found;

    assign valid_pad = 4'(valid);
    assign any_valid = |valid;

`ifdef SPI_ARB_FIXED_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = ^last_grant;

    always_comb begin
        winner_id = '0;
        found     = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && valid_pad[k]) begin
                found     = 1'b1;
                winner_id = 2'(k);
            end
        end
    end
`else
    logic [2:0] idx;

    // Walk the requesters starting just after the last winner, wrapping at
    // NUM_REQ; the first valid one found wins.
    always_comb begin
        winner_id = '0;
        found     = 1'b0;
        idx       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = {1'b0, last_grant} + 3'(k);
            if (idx >= 3'(NUM_REQ)) begin
                idx = idx - 3'(NUM_REQ);
            end
            if (!found && valid_pad[idx[1:0]]) begin
                found     = 1'b1;
                winner_id = idx[1:0];
            end
        end
    end
`endif

    assign winner = any_valid ? NUM_REQ'(4'b0001 << winner_id) : '0;

endmodule

// File: rtl/spi_cfg_arbiter.sv
// -----------------------------------------------------------------------------
// spi_cfg_arbiter
// Shares one SPI shifter among NUM_REQ AXI-Stream configuration requesters.
// One word is accepted in IDLE, forwarded to the shifter, the shifter's busy
// flag is tracked until the frame ends, then a GAP_CYCLES idle gap is enforced
// before the next requester can be accepted.
//
// Build option: define SPI_ARB_FIXED_PRIO_EN for fixed-priority arbitration
// (lowest index wins); otherwise round-robin.
//
// Ports:
//   clk            in                    clock, rising edge
//   resetn         in                    asynchronous active-low reset
//   s_axis_tdata   in  [32*NUM_REQ-1:0]  requester words, lane i = [32i+31:32i]
//   s_axis_tvalid  in  [NUM_REQ-1:0]     requester valids
//   s_axis_tready  out [NUM_REQ-1:0]     requester readies, at most one high
//   m_axis_tdata   out [31:0]            held word to the shifter
//   m_axis_tvalid  out                   held word valid
//   m_axis_tready  in                    shifter ready
//   spi_busy       in                    shifter frame in progress
//   grant          out [NUM_REQ-1:0]     one-hot frame owner, 0 when idle
//   grant_id       out [1:0]             binary frame owner
//   idle           out                   high only in IDLE
//   xfer_count     out [CNT_WIDTH-1:0]   completed frames, wrapping
// -----------------------------------------------------------------------------
module spi_cfg_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int GAP_CYCLES = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic [WORD_W*NUM_REQ-1:0]   s_axis_tdata,
    input  logic [NUM_REQ-1:0]          s_axis_tvalid,
    output logic [NUM_REQ-1:0]          s_axis_tready,
    output logic [WORD_W-1:0]           m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    input  logic                        spi_busy,
    output logic [NUM_REQ-1:0]          grant,
    output logic [1:0]                  grant_id,
    output logic                        idle,
    output logic [CNT_WIDTH-1:0]        xfer_count
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    arb_state_t           state;
    logic [1:0]           last_grant;
    logic [NUM_REQ-1:0]   winner;
    logic [1:0]           winner_id;
    logic                 any_valid;
    logic [WORD_W-1:0]    word_sel;
    logic [GAP_W-1:0]     gap_cnt;

    spi_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .valid      (s_axis_tvalid),
        .last_grant (last_grant),
        .winner     (winner),
        .winner_id  (winner_id),
        .any_valid  (any_valid)
    );

    // One-hot mux of the winning requester's word.
    always_comb begin
        word_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner[i]) begin
                word_sel = s_axis_tdata[i*WORD_W +: WORD_W];
            end
        end
    end

    // Ready is combinational from tvalid so the word is taken in the same
    // IDLE cycle; it is held low while reset is asserted.
    assign s_axis_tready = (resetn && (state == S_IDLE)) ? winner : '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= S_IDLE;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            grant         <= '0;
            grant_id      <= '0;
            idle          <= 1'b1;
            xfer_count    <= '0;
            last_grant    <= 2'(NUM_REQ - 1);
            gap_cnt       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_valid) begin
                        m_axis_tdata  <= word_sel;
                        m_axis_tvalid <= 1'b1;
                        grant         <= winner;
                        grant_id      <= winner_id;
                        last_grant    <= winner_id;
                        idle          <= 1'b0;
                        state         <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (m_axis_tready) begin
                        m_axis_tvalid <= 1'b0;
                        state         <= S_WAIT_START;
                    end
                end
                S_WAIT_START: begin
                    if (spi_busy) begin
                        state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (!spi_busy) begin
                        xfer_count <= xfer_count + CNT_WIDTH'(1);
                        gap_cnt    <= GAP_W'(GAP_CYCLES - 1);
                        state      <= S_GAP;
                    end
                end
                S_GAP: begin
                    // The gap spans GAP_CYCLES states counting down to zero;
                    // the owner is released on the last one.
                    if (gap_cnt == '0) begin
                        grant    <= '0;
                        grant_id <= '0;
                        idle     <= 1'b1;
                        state    <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: begin
                    m_axis_tvalid <= 1'b0;
                    grant         <= '0;
                    grant_id      <= '0;
                    idle          <= 1'b1;
                    state         <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/spi_cfg_arbiter.md
# spi_cfg_arbiter

Shares one SPI shifter among up to four AXI-Stream configuration requesters (e.g. PS register writes, AGC updates, calibration engine). It arbitrates among pending words and forwards one 32-bit word at a time to the shifter's AXI-Stream slave. It tracks the shifter's `busy` flag until the frame completes and enforces a minimum CS-high gap before the next grant. It sits between the requester FIFOs and the SPI shifter in the SDR transceiver control path.

## Interface
- `NUM_REQ`, 2: number of requesters, 2..4.
- `GAP_CYCLES`, 4: minimum idle `clk` cycles between end of one frame and the next issue, >= 1.
- `CNT_WIDTH`, 16: width of the completed-transfer counter.

- `clk` input 1: single clock; all logic on rising edge.
- `resetn` input 1: asynchronous, active-low reset.
- `s_axis_tdata` input 32*NUM_REQ: requester words; requester i occupies bits [32i+31:32i].
- `s_axis_tvalid` input NUM_REQ: per-requester valid.
- `s_axis_tready` output NUM_REQ: per-requester ready; at most one bit high per cycle.
- `m_axis_tdata` output 32: word to the SPI shifter.
- `m_axis_tvalid` output 1: word valid to the shifter.
- `m_axis_tready` input 1: shifter ready.
- `spi_busy` input 1: shifter busy flag; high while a frame is on the wire.
- `grant` output NUM_REQ: one-hot owner of the current frame; 0 when idle.
- `grant_id` output 2: binary index of the owner.
- `idle` output 1: high only in IDLE.
- `xfer_count` output CNT_WIDTH: number of completed frames; wraps modulo 2^CNT_WIDTH.

## Operation
- States: IDLE, ISSUE, WAIT_START, WAIT_DONE, GAP.
- IDLE: the arbiter picks a winner among asserted `s_axis_tvalid`.
  - `s_axis_tready[winner]` is high that cycle (combinational from tvalid; allowed by AXIS).
  - On handshake: capture word into the holding register, set `grant`/`grant_id`, go to ISSUE.
  - No valid requester: stay in IDLE.
- ISSUE: `m_axis_tvalid`=1 with the held word; data stays stable until `m_axis_tready`=1. On handshake go to WAIT_START.
- WAIT_START: wait for `spi_busy`=1, then go to WAIT_DONE.
- WAIT_DONE: wait for `spi_busy`=0. Then increment `xfer_count`, load the gap counter with GAP_CYCLES-1, and go to GAP.
- GAP: decrement the counter; at 0 clear `grant` and go to IDLE.
- Arbitration (default): round-robin. The search starts at last_grant+1 modulo NUM_REQ; last_grant updates on each upstream handshake.
- No requester is starved; with all requesters valid, grants rotate 0,1,...,NUM_REQ-1,0.
- A requester dropping tvalid before the handshake is simply skipped; no word is lost.
- A requester holding tvalid through a busy period is only ready-ed at the next IDLE.

## Timing
- Reset values (asynchronous, immediate):
  - `s_axis_tready`=0, `m_axis_tvalid`=0, `m_axis_tdata`=0.
  - `grant`=0, `grant_id`=0, `idle`=1, `xfer_count`=0.
  - last_grant=NUM_REQ-1, so requester 0 wins first.
- Upstream handshake at cycle N gives `m_axis_tvalid` high at cycle N+1.
- With a shifter whose tready is ~busy: busy rises at N+2, WAIT_START exits at N+2.
- After `spi_busy` falls, the next upstream ready is no earlier than GAP_CYCLES+1 cycles later.
- Simultaneous requests: exactly one ready per cycle, chosen by the arbitration rule.
- Reset mid-frame: return to IDLE at once and drop the held word. The shifter is reset by the same `resetn`.
- `xfer_count` wraps from all-ones to 0 without a flag.

## Configuration
- `SPI_ARB_FIXED_PRIO_EN` defined: fixed priority; the lowest index with tvalid always wins, and last_grant is unused.
- Not defined: round-robin as above.
- All other behaviour is identical in both builds.

## Structure
- Package `spi_arb_pkg`: state encoding (3-bit localparams for IDLE/ISSUE/WAIT_START/WAIT_DONE/GAP) and the 32-bit word width constant.
- Sub-module `spi_rr_arbiter`: combinational winner select from the valid vector and last_grant, with a fixed-priority path under the macro. It outputs a one-hot winner plus a binary index.
- The top holds the FSM, holding register, gap counter and transfer counter.

## Test plan
- Single request: req0 sends 0xA5A5_1234 with a busy model of 32 cycles. Expect `m_axis_tdata`=0xA5A5_1234 one cycle after the handshake, `grant`=0b01 throughout, `xfer_count`=1, and IDLE GAP_CYCLES+1 cycles after busy falls.
- Contention, round-robin: NUM_REQ=4 with all requesters valid for 8 words. Grant order must be 0,1,2,3,0,1,2,3 with exactly one tready per cycle.
- Contention with `SPI_ARB_FIXED_PRIO_EN`: req0 and req2 are valid continuously. Req0 wins every grant and req2 is never ready.
- Backpressure: `m_axis_tready` is held low for 10 cycles in ISSUE. `m_axis_tvalid` and the data must stay stable, and no upstream ready may occur.
- Reset mid-frame: assert `resetn`=0 during WAIT_DONE. All outputs take their reset values in the same cycle, and the next grant after release goes to req0.
- Counter wrap: CNT_WIDTH=4 with 17 frames. `xfer_count` must read 1.
